uart_rx_depacketiser: RTL and testbench

UART_RX_DEPACKETISER -- requirements
Module: uart_rx_depacketiser

---
 rtl/uart_rx_depacketiser_if.sv | 33 +++
 rtl/uart_rx_depacketiser.sv | 132 +++++++++++++
 tb/tb_uart_rx_depacketiser.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_depacketiser_if.sv
// ============================================================================
// Module   : uart_rx_depacketiser_if
// Brief    : Byte-in / payload-out bundle of the UART RX depacketiser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_depacketiser_if;
  logic [7:0] ipRxData;
  logic       ipRxValid;
  logic       opValid;
  logic       opSoP;
  logic       opEoP;
  logic [7:0] opDestination;
  logic [7:0] opSource;
  logic [7:0] opLength;
  logic [7:0] opData;
  logic       opError;

  // master: the UART / packet consumer side
  modport master (
    output ipRxData, ipRxValid,
    input  opValid, opSoP, opEoP, opDestination, opSource, opLength, opData, opError
  );

  // slave: the depacketiser itself
  modport slave (
    input  ipRxData, ipRxValid,
    output opValid, opSoP, opEoP, opDestination, opSource, opLength, opData, opError
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_depacketiser.sv
// ============================================================================
// Module   : uart_rx_depacketiser
// Brief    : Splits a UART byte stream (55 Dst Src Len payload) into packets.
//            Optional macro UART_RX_DEPACK_ADDR_FILTER_EN drops payload whose
//            Destination differs from ADDRESS.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_depacketiser #(
  parameter logic [7:0] ADDRESS        = 8'h7A,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  wire logic             ipClk,
  input  wire logic             ipReset,
  uart_rx_depacketiser_if.slave bus
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_DEST = 3'd1;
  localparam logic [2:0] c_SRC  = 3'd2;
  localparam logic [2:0] c_LEN  = 3'd3;
  localparam logic [2:0] c_DATA = 3'd4;

  localparam logic [7:0] c_SYNC  = 8'h55;
  localparam int         c_GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]         r_state;
  logic [c_GAP_W-1:0] r_gap;
  logic [7:0]         r_cnt;
  logic               r_first;
  logic               r_valid;
  logic               r_sop;
  logic               r_eop;
  logic               r_err;
  logic [7:0]         r_dest;
  logic [7:0]         r_src;
  logic [7:0]         r_len;
  logic [7:0]         r_data;
  logic               w_pass;
  logic               w_timeout;

`ifdef UART_RX_DEPACK_ADDR_FILTER_EN
  assign w_pass = (r_dest == ADDRESS);
`else
  // Every packet is forwarded; the compare is constant-folded away.
  assign w_pass = (r_dest == ADDRESS) | 1'b1;
`endif

  // A byte landing on the expiry cycle wins over the timeout.
  assign w_timeout = (r_state != c_IDLE) && !bus.ipRxValid &&
                     (r_gap == c_GAP_W'(TIMEOUT_CYCLES));

  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      r_state <= c_IDLE;
      r_gap   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_err   <= 1'b0;
      r_dest  <= '0;
      r_src   <= '0;
      r_len   <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_err   <= 1'b0;
      if (w_timeout) begin
        r_err   <= 1'b1;
        r_state <= c_IDLE;
        r_gap   <= '0;
      end else begin
        if (r_state == c_IDLE || bus.ipRxValid)
          r_gap <= '0;
        else
          r_gap <= r_gap + 1'b1;

        if (bus.ipRxValid) begin
          case (r_state)
            c_IDLE: if (bus.ipRxData == c_SYNC) r_state <= c_DEST;
            c_DEST: begin
              r_dest  <= bus.ipRxData;
              r_state <= c_SRC;
            end
            c_SRC: begin
              r_src   <= bus.ipRxData;
              r_state <= c_LEN;
            end
            c_LEN: begin
              r_len <= bus.ipRxData;
              if (bus.ipRxData == 8'h00) begin
                r_err   <= 1'b1;
                r_state <= c_IDLE;
              end else begin
                r_cnt   <= bus.ipRxData;
                r_first <= 1'b1;
                r_state <= c_DATA;
              end
            end
            c_DATA: begin
              r_valid <= w_pass;
              r_sop   <= w_pass & r_first;
              r_eop   <= w_pass & (r_cnt == 8'd1);
              if (w_pass) r_data <= bus.ipRxData;
              r_first <= 1'b0;
              r_cnt   <= r_cnt - 8'd1;
              if (r_cnt == 8'd1) r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.opValid       = r_valid;
  assign bus.opSoP         = r_sop;
  assign bus.opEoP         = r_eop;
  assign bus.opError       = r_err;
  assign bus.opDestination = r_dest;
  assign bus.opSource      = r_src;
  assign bus.opLength      = r_len;
  assign bus.opData        = r_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_depacketiser.sv
// ============================================================================
// Module   : tb_uart_rx_depacketiser
// Brief    : Directed self-checking bench for uart_rx_depacketiser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_depacketiser;
  localparam int c_T = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_vpulse = 0;
  int   n_epulse = 0;
  int   n_bad = 0;
  int   exp_v;
  int   exp_e;

  uart_rx_depacketiser_if bus();

  uart_rx_depacketiser #(.ADDRESS(8'h7A), .TIMEOUT_CYCLES(c_T)) dut (
    .ipClk   (clk),
    .ipReset (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.opValid) n_vpulse++;
    if (bus.opError) n_epulse++;
    if (!bus.opValid && (bus.opSoP || bus.opEoP)) n_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte; returns 1ns after the edge that sampled it.
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus.ipRxData  = b;
    bus.ipRxValid = 1'b1;
    @(posedge clk);
    #1;
    bus.ipRxValid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic s, input logic e);
    chk({tag, ".valid"}, bus.opValid, v);
    if (v) begin
      chk({tag, ".data"}, bus.opData, d);
      chk({tag, ".sop"},  bus.opSoP,  s);
      chk({tag, ".eop"},  bus.opEoP,  e);
    end
  endtask

  initial begin
    bus.ipRxData  = 8'h00;
    bus.ipRxValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", bus.opValid, 0);
    chk("rst.error", bus.opError, 0);
    chk("rst.dest",  bus.opDestination, 0);
    chk("rst.len",   bus.opLength, 0);
    @(negedge clk) rst_n = 1'b1;

    // Basic 4-byte packet
    push(8'h55); chk_out("p1.sync", 0, 0, 0, 0);
    push(8'h7A); chk_out("p1.dst", 0, 0, 0, 0);
    push(8'h2C); chk_out("p1.src", 0, 0, 0, 0);
    push(8'h04); chk_out("p1.len", 0, 0, 0, 0);
    push(8'h18); chk_out("p1.b0", 1, 8'h18, 1, 0);
    chk("p1.hdr", {8'h0, bus.opDestination, bus.opSource, bus.opLength}, 32'h007A2C04);
    push(8'h19); chk_out("p1.b1", 1, 8'h19, 0, 0);
    push(8'h1A); chk_out("p1.b2", 1, 8'h1A, 0, 0);
    push(8'h1B); chk_out("p1.b3", 1, 8'h1B, 0, 1);
    chk("p1.hdr_eop", {8'h0, bus.opDestination, bus.opSource, bus.opLength}, 32'h007A2C04);
    @(posedge clk); #1;
    chk_out("p1.after", 0, 0, 0, 0);
    chk("p1.errcnt", n_epulse, 0);

    // Junk before sync; 55 as payload; length 1
    push(8'h00); push(8'hAA); chk_out("p2.junk", 0, 0, 0, 0);
    push(8'h55); push(8'h7A); push(8'h2C); push(8'h01);
    push(8'h55); chk_out("p2.b0", 1, 8'h55, 1, 1);

    // Zero length aborts, next packet ok
    push(8'h55); push(8'h7A); push(8'h2C); push(8'h00);
    chk("p3.err", bus.opError, 1);
    chk("p3.valid", bus.opValid, 0);
    @(posedge clk); #1;
    chk("p3.err_pulse", bus.opError, 0);
    push(8'h55); push(8'h7A); push(8'h2C); push(8'h01);
    push(8'h42); chk_out("p3.next", 1, 8'h42, 1, 1);

    // Timeout: byte on expiry cycle accepted, then a real timeout
    push(8'h55); push(8'h7A); push(8'h2C); push(8'h03);
    push(8'h01); chk_out("p4.b0", 1, 8'h01, 1, 0);
    repeat (c_T) @(posedge clk);
    push(8'h02); chk_out("p4.expiry_byte", 1, 8'h02, 0, 0);
    chk("p4.no_err_yet", n_epulse, 1);
    repeat (c_T) @(posedge clk);
    #1;
    chk("p4.err_early", bus.opError, 0);
    @(posedge clk); #1;
    chk("p4.err", bus.opError, 1);
    chk("p4.valid", bus.opValid, 0);
    push(8'h03); chk_out("p4.dropped", 0, 0, 0, 0);

    // Reset mid-packet
    push(8'h55); push(8'h7A); push(8'h2C); push(8'h03);
    push(8'h01); chk_out("p5.b0", 1, 8'h01, 1, 0);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("p5.rst_outs", {bus.opValid, bus.opSoP, bus.opEoP, bus.opError,
                        bus.opDestination, bus.opSource, bus.opLength, bus.opData}, 0);
    @(negedge clk) rst_n = 1'b1;
    push(8'h02); push(8'h03); chk_out("p5.no_resume", 0, 0, 0, 0);
    push(8'h55); push(8'h7A); push(8'h2C); push(8'h02);
    push(8'hA1); chk_out("p5.n0", 1, 8'hA1, 1, 0);
    push(8'hA2); chk_out("p5.n1", 1, 8'hA2, 0, 1);
    chk("p5.errcnt", n_epulse, 2);

    // Length 255 without wrap
    push(8'h55); push(8'h7A); push(8'h2C); push(8'hFF);
    for (int i = 0; i < 255; i++) begin
      push(8'(i));
      if (i == 0)   chk_out("p6.first", 1, 8'h00, 1, 0);
      if (i == 253) chk_out("p6.penult", 1, 8'hFD, 0, 0);
      if (i == 254) chk_out("p6.last", 1, 8'hFE, 0, 1);
    end
    push(8'h77); chk_out("p6.after", 0, 0, 0, 0);

    exp_v = 4 + 1 + 1 + 2 + 3 + 255;
`ifdef UART_RX_DEPACK_ADDR_FILTER_EN
    push(8'h55); push(8'h3B); push(8'h2C); push(8'h02);
    push(8'hAA); chk_out("p7.f0", 0, 0, 0, 0);
    push(8'hBB); chk_out("p7.f1", 0, 0, 0, 0);
    push(8'h55); push(8'h7A); push(8'h2C); push(8'h01);
    push(8'hCC); chk_out("p7.ok", 1, 8'hCC, 1, 1);
    exp_v = exp_v + 1;
`endif
    exp_e = 2;
    @(posedge clk); #1;
    chk("tot.valid", n_vpulse, exp_v);
    chk("tot.error", n_epulse, exp_e);
    chk("tot.strobe_qual", n_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
